// File: rtl/seg7_pkg.sv
// Shared types and the hex-to-segment table for the 7-segment scan driver.
package seg7_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  typedef enum logic [0:0] {
    StIdle,
    StScan
  } state_e;

  // Segment order {g,f,e,d,c,b,a}, active-low.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    logic [6:0] seg;
    unique case (nibble)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = SEG_OFF;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational nibble to active-low segment decoder.
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver, advanced by an asynchronous scan strobe
// with leading-zero blanking and per-digit decimal point.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned IDX_W      = 2
) (
  input  logic                    clk_in,
  input  logic                    rst,
  input  logic                    scan_clk,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [IDX_W-1:0]        digit_idx,
  output logic                    scan_tick
);

  logic s1_q, s2_q, s3_q;
  logic scan_tick_q;
  logic rise;

  state_e state_q, state_d;
  logic   load;

  logic [IDX_W-1:0]      idx_q, idx_d, idx_adv;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;

  logic [NUM_DIGITS-1:0] upper_zero;
  logic [3:0]            nibble;
  logic [6:0]            dec_seg;
  logic                  blank;

  assign rise = s2_q & ~s3_q;

  // upper_zero[k]: nibbles k..NUM_DIGITS-1 are all zero.
  always_comb begin
    upper_zero = '0;
    upper_zero[NUM_DIGITS-1] = (value[4*(NUM_DIGITS-1) +: 4] == 4'h0);
    for (int k = int'(NUM_DIGITS) - 2; k >= 0; k--) begin
      upper_zero[k] = upper_zero[k+1] & (value[4*k +: 4] == 4'h0);
    end
  end

  // Index of the digit to drive on a load: first digit after IDLE, else next with wrap.
  always_comb begin
    idx_adv = '0;
    if (state_q == StScan) begin
      idx_adv = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
  end

  assign nibble = value[{idx_adv, 2'b00} +: 4];
  assign blank  = (idx_adv != '0) && blank_lz && upper_zero[idx_adv];

  seg7_hex_decoder u_hex_decoder (
    .nibble (nibble),
    .seg    (dec_seg)
  );

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rise && enable) begin
          state_d = StScan;
          load    = 1'b1;
        end
      end
      StScan: begin
        if (!enable) begin
          state_d = StIdle;
        end else if (rise) begin
          load = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    idx_d = idx_q;
    an_d  = an_q;
    seg_d = seg_q;
    dp_d  = dp_q;
    if (state_d == StIdle) begin
      idx_d = '0;
      an_d  = '1;
      seg_d = SEG_OFF;
      dp_d  = 1'b1;
    end else if (load) begin
      idx_d = idx_adv;
      an_d  = ~(NUM_DIGITS'(1) << idx_adv);
      seg_d = blank ? SEG_OFF : dec_seg;
      dp_d  = ~dp_in[idx_adv];
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      s3_q        <= 1'b0;
      scan_tick_q <= 1'b0;
      idx_q       <= '0;
      an_q        <= '1;
      seg_q       <= SEG_OFF;
      dp_q        <= 1'b1;
    end else begin
      s1_q        <= scan_clk;
      s2_q        <= s1_q;
      s3_q        <= s2_q;
      scan_tick_q <= rise;
      idx_q       <= idx_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end

  assign an        = an_q;
  assign seg       = seg_q;
  assign dp        = dp_q;
  assign digit_idx = idx_q;
  assign scan_tick = scan_tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with hand-computed expected segment patterns.
module tb_seg7_scan_driver;

  logic        clk_in = 1'b0;
  logic        rst = 1'b1;
  logic        scan_clk = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic        blank_lz = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [1:0]  digit_idx;
  logic        scan_tick;

  int n_vec = 0;
  int n_err = 0;

  seg7_scan_driver #(
    .NUM_DIGITS (4),
    .IDX_W      (2)
  ) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .scan_clk  (scan_clk),
    .enable    (enable),
    .value     (value),
    .dp_in     (dp_in),
    .blank_lz  (blank_lz),
    .an        (an),
    .seg       (seg),
    .dp        (dp),
    .digit_idx (digit_idx),
    .scan_tick (scan_tick)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_digit(input string tag, input logic [3:0] exp_an,
                             input logic [1:0] exp_idx, input logic [6:0] exp_seg,
                             input logic exp_dp);
    check({tag, ".an"}, 32'(an), 32'(exp_an));
    check({tag, ".idx"}, 32'(digit_idx), 32'(exp_idx));
    check({tag, ".seg"}, 32'(seg), 32'(exp_seg));
    check({tag, ".dp"}, 32'(dp), 32'(exp_dp));
  endtask

  // Low 4 cycles, then high; returns on the cycle the tick is visible.
  task automatic scan_edge();
    repeat (2) @(negedge clk_in);
    scan_clk = 1'b0;
    repeat (4) @(negedge clk_in);
    scan_clk = 1'b1;
    repeat (3) @(negedge clk_in);
    check("tick", 32'(scan_tick), 32'd1);
  endtask

  initial begin
    // Reset held while scan_clk toggles
    @(negedge clk_in);
    for (int i = 0; i < 10; i++) begin
      if (i % 3 == 0) scan_clk = ~scan_clk;
      @(negedge clk_in);
      check("rst.an", 32'(an), 32'hF);
      check("rst.seg", 32'(seg), 32'h7F);
      check("rst.dp", 32'(dp), 32'd1);
      check("rst.tick", 32'(scan_tick), 32'd0);
    end
    scan_clk = 1'b0;
    rst      = 1'b0;
    repeat (6) @(negedge clk_in);
    check("idle.an", 32'(an), 32'hF);
    check("idle.tick", 32'(scan_tick), 32'd0);

    // Latency: tick and digit 0 on the 3rd edge after the strobe rises
    value    = 16'h12AF;
    enable   = 1'b1;
    scan_clk = 1'b1;
    @(negedge clk_in);
    check("lat.tick1", 32'(scan_tick), 32'd0);
    check("lat.an1", 32'(an), 32'hF);
    @(negedge clk_in);
    check("lat.tick2", 32'(scan_tick), 32'd0);
    check("lat.an2", 32'(an), 32'hF);
    @(negedge clk_in);
    check("lat.tick3", 32'(scan_tick), 32'd1);
    check_digit("lat.d0", 4'b1110, 2'd0, 7'b0001110, 1'b1);
    @(negedge clk_in);
    check("lat.tick4", 32'(scan_tick), 32'd0);
    check("lat.hold", 32'(an), 32'b1110);

    // Scan and wrap
    scan_edge(); check_digit("scan.d1", 4'b1101, 2'd1, 7'b0001000, 1'b1);
    scan_edge(); check_digit("scan.d2", 4'b1011, 2'd2, 7'b0100100, 1'b1);
    scan_edge(); check_digit("scan.d3", 4'b0111, 2'd3, 7'b1111001, 1'b1);
    scan_edge(); check_digit("scan.wrap", 4'b1110, 2'd0, 7'b0001110, 1'b1);

    // Leading-zero blanking
    value    = 16'h0030;
    blank_lz = 1'b1;
    scan_edge(); check_digit("blz.d1", 4'b1101, 2'd1, 7'b0110000, 1'b1);
    scan_edge(); check_digit("blz.d2", 4'b1011, 2'd2, 7'h7F, 1'b1);
    scan_edge(); check_digit("blz.d3", 4'b0111, 2'd3, 7'h7F, 1'b1);
    scan_edge(); check_digit("blz.d0", 4'b1110, 2'd0, 7'b1000000, 1'b1);
    blank_lz = 1'b0;
    scan_edge(); check_digit("nlz.d1", 4'b1101, 2'd1, 7'b0110000, 1'b1);
    scan_edge(); check_digit("nlz.d2", 4'b1011, 2'd2, 7'b1000000, 1'b1);
    scan_edge(); check_digit("nlz.d3", 4'b0111, 2'd3, 7'b1000000, 1'b1);
    scan_edge(); check_digit("nlz.d0", 4'b1110, 2'd0, 7'b1000000, 1'b1);

    // Enable drop at digit 2, coincident with an edge
    scan_edge();
    scan_edge(); check_digit("en.d2", 4'b1011, 2'd2, 7'b1000000, 1'b1);
    repeat (2) @(negedge clk_in);
    scan_clk = 1'b0;
    repeat (4) @(negedge clk_in);
    scan_clk = 1'b1;
    repeat (2) @(negedge clk_in);
    enable = 1'b0;
    @(negedge clk_in);
    check("en.tick", 32'(scan_tick), 32'd1);
    check_digit("en.off", 4'hF, 2'd0, 7'h7F, 1'b1);
    enable = 1'b1;
    repeat (3) @(negedge clk_in);
    check("en.wait", 32'(an), 32'hF);
    scan_edge(); check_digit("en.d0", 4'b1110, 2'd0, 7'b1000000, 1'b1);

    // Value changes between ticks are held off; dp follows dp_in of the driven digit
    dp_in = 4'b0100;
    value = 16'h12A5;
    repeat (2) @(negedge clk_in);
    check("hold.seg0", 32'(seg), 32'b1000000);
    scan_edge(); check_digit("dp.d1", 4'b1101, 2'd1, 7'b0001000, 1'b1);
    value = 16'h3456;
    repeat (2) @(negedge clk_in);
    check("hold.seg1", 32'(seg), 32'b0001000);
    scan_edge(); check_digit("dp.d2", 4'b1011, 2'd2, 7'b0011001, 1'b0);
    scan_edge(); check_digit("dp.d3", 4'b0111, 2'd3, 7'b0110000, 1'b1);
    scan_edge(); check_digit("dp.d0", 4'b1110, 2'd0, 7'b0000010, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
